// File: rtl/multicycle_cpu_ctrl.sv
// multicycle_cpu_ctrl: multi-cycle sequencer for the RISC core.
// Owns PC, IR and per-phase control strobes, stepping each instruction
// through FETCH/DECODE/EXECUTE/MEM/WRITEBACK.
// Optional macro PERF_CNT_EN adds the cycle_cnt/instr_cnt performance
// counters and their CNT_W width parameter.
//
// Handshakes: a request (imem_req / dmem_req) is held high for as long as
// the FSM sits in the requesting state; the matching ack is a one-cycle
// completion pulse that is only looked at while that request is high, and
// the transfer completes on the rising edge where req and ack are both 1.
// Acks seen in any other state are ignored.

module multicycle_cpu_ctrl #(
  parameter int unsigned           PC_W     = 32,
  parameter int unsigned           INSTR_W  = 32,
  parameter logic [PC_W-1:0]       RESET_PC = '0,
  parameter logic [PC_W-1:0]       PC_STEP  = PC_W'(4)
`ifdef PERF_CNT_EN
  ,parameter int unsigned          CNT_W    = 32
`endif
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] ir,
  input  logic               dec_is_mem,
  input  logic               dec_is_store,
  input  logic               dec_is_branch,
  input  logic               dec_is_halt,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic               alu_en,
  output logic               dmem_req,
  output logic               dmem_we,
  input  logic               dmem_ack,
  output logic               regf_we,
  output logic [PC_W-1:0]    pc,
  output logic [2:0]         state,
  output logic               halted
`ifdef PERF_CNT_EN
  ,output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]   instr_cnt
`endif
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  state_t state_q;
  state_t state_d;

  // Decoder flags captured in DECODE; stable until the next DECODE.
  logic is_mem_q;
  logic is_store_q;
  logic is_branch_q;

  // ALU branch result captured in EXECUTE for updates made in later phases.
  logic            taken_q;
  logic [PC_W-1:0] target_q;

  // Sequential successor and the latched-branch-aware next PC.
  logic [PC_W-1:0] pc_seq;
  logic [PC_W-1:0] pc_upd;

  assign pc_seq = pc + PC_STEP;
  assign pc_upd = (is_branch_q && taken_q) ? target_q : pc_seq;

  // State register; reset lands in FETCH immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; halt from the decoder overrides every other flag.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (imem_ack) state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d = dec_is_halt ? S_HALT : S_EXECUTE;
      end
      S_EXECUTE: begin
        if (is_mem_q)         state_d = S_MEM;
        else if (is_branch_q) state_d = S_FETCH;
        else                  state_d = S_WRITEBACK;
      end
      S_MEM: begin
        if (dmem_ack) state_d = is_store_q ? S_FETCH : S_WRITEBACK;
      end
      S_WRITEBACK: begin
        state_d = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Moore strobes decoded from state, forced low while reset is asserted.
  always_comb begin
    imem_req = 1'b0;
    alu_en   = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    regf_we  = 1'b0;
    halted   = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH:     imem_req = 1'b1;
        S_EXECUTE:   alu_en   = 1'b1;
        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = is_store_q;
        end
        S_WRITEBACK: regf_we  = 1'b1;
        S_HALT:      halted   = 1'b1;
        default:     ;
      endcase
    end
  end

  assign imem_addr = pc;
  assign state     = state_q;

  // Datapath registers: IR load, flag latching and the three PC update points.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      ir          <= '0;
      is_mem_q    <= 1'b0;
      is_store_q  <= 1'b0;
      is_branch_q <= 1'b0;
      taken_q     <= 1'b0;
      target_q    <= '0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (imem_ack) ir <= imem_rdata;
        end
        S_DECODE: begin
          is_mem_q    <= dec_is_mem;
          is_store_q  <= dec_is_store;
          is_branch_q <= dec_is_branch;
        end
        S_EXECUTE: begin
          taken_q  <= branch_taken;
          target_q <= branch_target;
          // A plain branch retires here, so use the live ALU result.
          if (!is_mem_q && is_branch_q) begin
            pc <= branch_taken ? branch_target : pc_seq;
          end
        end
        S_MEM: begin
          if (dmem_ack && is_store_q) pc <= pc_upd;
        end
        S_WRITEBACK: begin
          pc <= pc_upd;
        end
        default: ;
      endcase
    end
  end

`ifdef PERF_CNT_EN
  logic retire;

  // An instruction retires whenever a post-decode phase hands back to FETCH.
  always_comb begin
    retire = 1'b0;
    if ((state_q == S_EXECUTE || state_q == S_MEM || state_q == S_WRITEBACK) &&
        state_d == S_FETCH) begin
      retire = 1'b1;
    end
  end

  // Performance counters; both freeze once the core halts and wrap silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else if (state_q != S_HALT) begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (retire) instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_cpu_ctrl.sv
// tb_multicycle_cpu_ctrl: directed and random instruction sequences against
// multicycle_cpu_ctrl with RESET_PC=0x100. Outputs are sampled and inputs
// driven on the falling clock edge. Expected next-PC values are queued when
// an instruction is fetched and popped when the controller returns to FETCH.

module tb_multicycle_cpu_ctrl;

  localparam logic [31:0] RST_PC = 32'h100;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] ir;
  logic        dec_is_mem = 1'b0;
  logic        dec_is_store = 1'b0;
  logic        dec_is_branch = 1'b0;
  logic        dec_is_halt = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        alu_en;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack = 1'b0;
  logic        regf_we;
  logic [31:0] pc;
  logic [2:0]  state;
  logic        halted;
`ifdef PERF_CNT_EN
  logic [31:0] cycle_cnt;
  logic [31:0] instr_cnt;
`endif

  multicycle_cpu_ctrl #(
    .PC_W(32), .INSTR_W(32), .RESET_PC(RST_PC), .PC_STEP(32'd4)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .ir(ir),
    .dec_is_mem(dec_is_mem), .dec_is_store(dec_is_store),
    .dec_is_branch(dec_is_branch), .dec_is_halt(dec_is_halt),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .alu_en(alu_en), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_ack(dmem_ack), .regf_we(regf_we), .pc(pc), .state(state),
    .halted(halted)
`ifdef PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
  );

  // Scoreboard
  logic [31:0] exp_q[$];
  logic [31:0] pc_model;
  int vectors = 0;
  int miscompares = 0;
  int regf_pulses = 0;

  always @(negedge clk) begin
    if (!rst && regf_we === 1'b1) regf_pulses++;
  end

  // Driver: one instruction. kind 0=ALU 1=load 2=store 3=branch 5=store flag w/o mem.
  // Entered and left on a falling edge with the controller in FETCH.
  task automatic run_instr(input int kind, input int idly, input int ddly,
                           input logic taken, input logic [31:0] target);
    logic [31:0] word, nxt, got;
    logic is_mem, is_store, is_br, has_wb;
    int cyc, exp_cyc, rf0;
    word     = $urandom;
    is_mem   = (kind == 1 || kind == 2);
    is_store = (kind == 2 || kind == 5);
    is_br    = (kind == 3);
    has_wb   = !is_br && !(is_mem && is_store);
    nxt      = (is_br && taken) ? target : pc_model + 32'd4;
    exp_q.push_back(nxt);
    rf0 = regf_pulses;
    cyc = 0;
    for (int i = 0; i <= idly; i++) begin
      vectors++;
      if ({state, imem_req, alu_en, dmem_req, regf_we, imem_addr} !==
          {3'd0, 4'b1000, pc_model}) begin
        miscompares++;
        $display("FAIL fetch_phase: got st=%0d req=%b addr=%h expected st=0 req=1 addr=%h",
                 state, imem_req, imem_addr, pc_model);
      end
      imem_ack   = (i == idly);
      imem_rdata = word;
      dmem_ack   = 1'($urandom_range(0, 1));
      @(negedge clk); cyc++;
    end
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    dmem_ack   = 1'b0;
    vectors++;
    if ({state, imem_req, alu_en, dmem_req, regf_we, ir} !== {3'd1, 4'b0000, word}) begin
      miscompares++;
      $display("FAIL decode_phase: got st=%0d ir=%h expected st=1 ir=%h", state, ir, word);
    end
    dec_is_mem    = is_mem;
    dec_is_store  = is_store;
    dec_is_branch = is_br;
    dec_is_halt   = 1'b0;
    @(negedge clk); cyc++;
    // Flags scrambled after DECODE: the controller must use its latched copy.
    dec_is_mem    = 1'($urandom_range(0, 1));
    dec_is_store  = 1'($urandom_range(0, 1));
    dec_is_branch = 1'($urandom_range(0, 1));
    dec_is_halt   = 1'($urandom_range(0, 1));
    vectors++;
    if ({state, imem_req, alu_en, dmem_req, regf_we} !== {3'd2, 4'b0100}) begin
      miscompares++;
      $display("FAIL execute_phase: got st=%0d alu_en=%b expected st=2 alu_en=1", state, alu_en);
    end
    branch_taken  = taken;
    branch_target = target;
    @(negedge clk); cyc++;
    branch_taken  = 1'($urandom_range(0, 1));
    branch_target = $urandom;
    if (is_mem) begin
      for (int j = 0; j <= ddly; j++) begin
        vectors++;
        if ({state, imem_req, alu_en, dmem_req, dmem_we, regf_we} !==
            {3'd3, 3'b001, is_store, 1'b0}) begin
          miscompares++;
          $display("FAIL mem_phase: got st=%0d dreq=%b dwe=%b expected st=3 dreq=1 dwe=%b",
                   state, dmem_req, dmem_we, is_store);
        end
        dmem_ack = (j == ddly);
        imem_ack = 1'($urandom_range(0, 1));
        @(negedge clk); cyc++;
      end
      dmem_ack = 1'b0;
      imem_ack = 1'b0;
    end
    if (has_wb) begin
      vectors++;
      if ({state, imem_req, alu_en, dmem_req, regf_we} !== {3'd4, 4'b0001}) begin
        miscompares++;
        $display("FAIL wb_phase: got st=%0d regf_we=%b expected st=4 regf_we=1", state, regf_we);
      end
      @(negedge clk); cyc++;
    end
    got = exp_q.pop_front();
    vectors++;
    if ({state, pc} !== {3'd0, got}) begin
      miscompares++;
      $display("FAIL next_pc: got st=%0d pc=%h expected st=0 pc=%h", state, pc, got);
    end
    pc_model = got;
    exp_cyc = (idly + 1) + 2 + (is_mem ? ddly + 1 : 0) + (has_wb ? 1 : 0);
    vectors++;
    if (cyc !== exp_cyc) begin
      miscompares++;
      $display("FAIL cycle_count: got %0d expected %0d (kind %0d)", cyc, exp_cyc, kind);
    end
    vectors++;
    if (regf_pulses - rf0 !== (has_wb ? 1 : 0)) begin
      miscompares++;
      $display("FAIL regf_pulses: got %0d expected %0d", regf_pulses - rf0, has_wb ? 1 : 0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({state, pc, ir, halted, imem_req, alu_en, dmem_req, dmem_we, regf_we} !==
        {3'd0, RST_PC, 32'd0, 6'b000000}) begin
      miscompares++;
      $display("FAIL reset_state: got st=%0d pc=%h ir=%h strobes=%b expected st=0 pc=%h ir=0 strobes=0",
               state, pc, ir, {halted, imem_req, alu_en, dmem_req, dmem_we, regf_we}, RST_PC);
    end
`ifdef PERF_CNT_EN
    vectors++;
    if ({cycle_cnt, instr_cnt} !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_counters: got %0d/%0d expected 0/0", cycle_cnt, instr_cnt);
    end
`endif
    rst = 1'b0;
    @(negedge clk);
    pc_model = RST_PC;
  endtask

  task automatic test_directed();
    run_instr(0, 0, 0, 1'b0, 32'h0);                 // ALU, 4 cycles, 0x100->0x104
    run_instr(1, 2, 3, 1'b0, 32'h0);                 // load with delayed acks
    run_instr(2, 0, 0, 1'b0, 32'h0);                 // store, 4 cycles
    run_instr(2, 1, 2, 1'b0, 32'h0);                 // store with delayed acks
    run_instr(5, 0, 0, 1'b0, 32'h0);                 // store flag without mem -> ALU
    run_instr(3, 0, 0, 1'b1, 32'h200);               // reach 0x200
    run_instr(3, 0, 0, 1'b1, 32'h40);                // taken: 0x200 -> 0x40
    run_instr(3, 0, 0, 1'b1, 32'h200);
    run_instr(3, 0, 0, 1'b0, 32'h40);                // not taken: 0x200 -> 0x204
    run_instr(3, 0, 0, 1'b1, 32'hFFFF_FFFC);
    run_instr(0, 0, 0, 1'b0, 32'h0);                 // wraps to 0x0
  endtask

  task automatic test_back_to_back();
    int k;
    for (int n = 0; n < 12; n++) begin
      k = $urandom_range(0, 4);
      if (k == 4) k = 5;
      run_instr(k, $urandom_range(0, 2), $urandom_range(0, 2),
                1'($urandom_range(0, 1)), {$urandom_range(0, 32'h3FFF), 2'b00});
    end
  endtask

  task automatic test_reset_mid_mem();
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    dec_is_mem = 1'b1; dec_is_store = 1'b0; dec_is_branch = 1'b0; dec_is_halt = 1'b0;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if ({state, dmem_req} !== {3'd3, 1'b1}) begin
      miscompares++;
      $display("FAIL pre_reset_mem: got st=%0d dreq=%b expected st=3 dreq=1", state, dmem_req);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({state, pc, imem_req, alu_en, dmem_req, dmem_we, regf_we, halted} !==
        {3'd0, RST_PC, 6'b000000}) begin
      miscompares++;
      $display("FAIL mid_mem_reset: got st=%0d pc=%h strobes=%b expected st=0 pc=%h strobes=0",
               state, pc, {imem_req, alu_en, dmem_req, dmem_we, regf_we, halted}, RST_PC);
    end
`ifdef PERF_CNT_EN
    vectors++;
    if ({cycle_cnt, instr_cnt} !== 64'd0) begin
      miscompares++;
      $display("FAIL mid_mem_counters: got %0d/%0d expected 0/0", cycle_cnt, instr_cnt);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pc_model = RST_PC;
    run_instr(0, 0, 0, 1'b0, 32'h0);
  endtask

  task automatic test_halt();
    int bad;
`ifdef PERF_CNT_EN
    logic [31:0] cc, ic;
`endif
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    dec_is_halt = 1'b1; dec_is_mem = 1'b1; dec_is_branch = 1'b1; dec_is_store = 1'b1;
    @(negedge clk);
    vectors++;
    if ({state, halted, pc} !== {3'd5, 1'b1, pc_model}) begin
      miscompares++;
      $display("FAIL halt_entry: got st=%0d halted=%b pc=%h expected st=5 halted=1 pc=%h",
               state, halted, pc, pc_model);
    end
`ifdef PERF_CNT_EN
    cc = cycle_cnt; ic = instr_cnt;
`endif
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      imem_ack = 1'($urandom_range(0, 1));
      dmem_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      if ({state, halted, imem_req, alu_en, dmem_req, regf_we, pc} !==
          {3'd5, 5'b10000, pc_model}) bad++;
    end
    imem_ack = 1'b0; dmem_ack = 1'b0; dec_is_halt = 1'b0;
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL halt_sticky: got %0d bad cycles expected 0", bad);
    end
`ifdef PERF_CNT_EN
    vectors++;
    if ({cycle_cnt, instr_cnt} !== {cc, ic}) begin
      miscompares++;
      $display("FAIL halt_freeze: got %0d/%0d expected %0d/%0d", cycle_cnt, instr_cnt, cc, ic);
    end
`endif
    // Only reset leaves HALT.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({state, halted, imem_req, pc} !== {3'd0, 2'b01, RST_PC}) begin
      miscompares++;
      $display("FAIL halt_exit: got st=%0d halted=%b req=%b pc=%h expected st=0 halted=0 req=1 pc=%h",
               state, halted, imem_req, pc, RST_PC);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid_mem();
    test_halt();
    vectors++;
    if (exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
